// File: rtl/rs485_rx_frame_decoder.sv
// Purpose : RS-485 slave receive front end; decodes 11-bit 9-bit-mode UART frames, matches addresses, delivers data bytes.
// Latency : result pulses 2 + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT + 1 clk after the start-bit falling edge at the pin.
// Backpressure: none; the line cannot be stalled, every pulse is one clk wide and must be taken when it appears.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   Rx         asynchronous receive line, idle high
//   tx_active  local transmitter owns the bus; receiver ignores the line and aborts any frame in progress
//   rx_data    last data byte accepted while addressed
//   rx_valid   one-clk pulse, rx_data just updated
//   addr_match one-clk pulse, address frame equal to SLAVE_ADDR (feeds the Tx controller seq_detect)
//   addressed  level, slave selected by own or broadcast address
//   frame_err  one-clk pulse, stop bit sampled low
//   busy       receiver is inside a frame
//
// Build option: define RX_MAJORITY_EN to take every bit (and the start check)
// as the 2-of-3 majority of the last three synchronised samples ending at the
// sample point. Sample timing relative to the state machine is identical.

module rs485_rx_frame_decoder #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] SLAVE_ADDR   = 8'h01,
    parameter logic [7:0] BCAST_ADDR   = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx,
    input  logic       tx_active,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       addressed,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    // Start check lands mid start bit; every later bit is sampled one full
    // bit time after the previous sample, i.e. mid-cell.
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] MODE  = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic          rx_s1;
    logic          rs;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          mode_bit;
    // Set after a framing error: the line may still be low (break), so the
    // start detector stays disarmed until the line has been seen high.
    logic          wait_high;
    logic          bit_val;

`ifdef RX_MAJORITY_EN
    logic rs_d1;
    logic rs_d2;

    always_ff @(posedge clk) begin
        if (reset) begin
            rs_d1 <= 1'b1;
            rs_d2 <= 1'b1;
        end else begin
            rs_d1 <= rs;
            rs_d2 <= rs_d1;
        end
    end

    // Samples at sample point -2, -1 and 0; a single-clk spike cannot flip it.
    assign bit_val = (rs_d2 & rs_d1) | (rs_d2 & rs) | (rs_d1 & rs);
`else
    assign bit_val = rs;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1      <= 1'b1;
            rs         <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'h00;
            mode_bit   <= 1'b0;
            wait_high  <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
            addressed  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= Rx;
            rs         <= rx_s1;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
            frame_err  <= 1'b0;

            if (tx_active && state != IDLE) begin
                // Our own transmission owns the bus: drop the partial frame.
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!tx_active) begin
                            if (wait_high) begin
                                if (rs) begin
                                    wait_high <= 1'b0;
                                end
                            end else if (!rs) begin
                                state <= START;
                                cnt   <= '0;
                            end
                        end
                    end

                    START: begin
                        if (cnt == HALF_LAST) begin
                            cnt     <= '0;
                            bit_idx <= 3'd0;
                            // Line back high by mid start bit: a glitch, not a frame.
                            state   <= bit_val ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    DATA: begin
                        if (cnt == BIT_LAST) begin
                            cnt            <= '0;
                            shreg[bit_idx] <= bit_val;
                            if (bit_idx == 3'd7) begin
                                state <= MODE;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    MODE: begin
                        if (cnt == BIT_LAST) begin
                            cnt      <= '0;
                            mode_bit <= bit_val;
                            state    <= STOP;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    STOP: begin
                        if (cnt == BIT_LAST) begin
                            cnt   <= '0;
                            state <= DONE;
                            // Results are registered here so that they appear
                            // together during the single DONE cycle.
                            if (!bit_val) begin
                                frame_err <= 1'b1;
                                wait_high <= 1'b1;
                            end else if (mode_bit) begin
                                if (shreg == SLAVE_ADDR) begin
                                    addressed  <= 1'b1;
                                    addr_match <= 1'b1;
                                end else if (shreg == BCAST_ADDR) begin
                                    addressed <= 1'b1;
                                end else begin
                                    addressed <= 1'b0;
                                end
                            end else if (addressed) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    DONE: begin
                        state <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    // At most one kind of result per frame.
    a_one_result: assert property (@(posedge clk) disable iff (reset)
        !(rx_valid && (addr_match || frame_err)) && !(addr_match && frame_err));
    // Data is only delivered to a selected slave.
    a_valid_addressed: assert property (@(posedge clk) disable iff (reset)
        rx_valid |-> addressed);
`endif

endmodule

// File: tb/tb_rs485_rx_frame_decoder.sv
// Purpose : directed, table-driven check of rs485_rx_frame_decoder at CLKS_PER_BIT=16, SLAVE_ADDR=8'h01.
// Latency : data/address results expected 171 clk after the start edge is driven.
// Backpressure: n/a (bench drives the line, counts pulses at negedge).

module tb_rs485_rx_frame_decoder;

    localparam int CPB = 16;
    localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;

    logic       clk;
    logic       reset;
    logic       Rx;
    logic       tx_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       addressed;
    logic       frame_err;
    logic       busy;

    rs485_rx_frame_decoder #(
        .CLKS_PER_BIT (CPB),
        .SLAVE_ADDR   (8'h01),
        .BCAST_ADDR   (8'hFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Rx         (Rx),
        .tx_active  (tx_active),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .addr_match (addr_match),
        .addressed  (addressed),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts cycles each pulse is high, so a stretched pulse
    // shows up as a count of 2.
    int n_valid = 0;
    int n_match = 0;
    int n_err   = 0;
    int n_busy_tx = 0;
    int last_cyc = 0;
    int t_start  = 0;

    always @(negedge clk) begin
        if (rx_valid)   n_valid++;
        if (addr_match) n_match++;
        if (frame_err)  n_err++;
        if (rx_valid || addr_match || frame_err) last_cyc = cyc;
        if (tx_active && busy) n_busy_tx++;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_counts();
        n_valid   = 0;
        n_match   = 0;
        n_err     = 0;
        n_busy_tx = 0;
    endtask

    // Drives ncells bit cells (start, d[0..7], mode, stop) then idles high.
    // spike_cell >= 0 inverts that cell for one clk at its midpoint.
    task automatic send_frame(input logic [7:0] d, input logic m, input logic s,
                              input int ncells, input int spike_cell);
        logic [10:0] bits;
        bits = {s, m, d, 1'b0};
        @(posedge clk);
        #1;
        t_start = cyc;
        for (int j = 0; j < ncells; j++) begin
            for (int c = 0; c < CPB; c++) begin
                Rx = (j == spike_cell && c == CPB / 2) ? ~bits[j] : bits[j];
                @(posedge clk);
                #1;
            end
        end
        Rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] dat;
        logic       mode;
        logic       stop;
        int         e_valid;
        int         e_match;
        int         e_err;
        logic       e_addr;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h01, 1'b1, 1'b1, 0, 1, 0, 1'b1, 8'h00};
        vecs[1] = '{8'h3F, 1'b0, 1'b1, 1, 0, 0, 1'b1, 8'h3F};
        vecs[2] = '{8'h0A, 1'b0, 1'b1, 1, 0, 0, 1'b1, 8'h0A};
        vecs[3] = '{8'h05, 1'b1, 1'b1, 0, 0, 0, 1'b0, 8'h0A};
        vecs[4] = '{8'h55, 1'b0, 1'b1, 0, 0, 0, 1'b0, 8'h0A};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 0, 0, 0, 1'b1, 8'h0A};
        vecs[6] = '{8'h55, 1'b0, 1'b1, 1, 0, 0, 1'b1, 8'h55};
        vecs[7] = '{8'h01, 1'b1, 1'b0, 0, 0, 1, 1'b1, 8'h55};
        vecs[8] = '{8'h05, 1'b1, 1'b1, 0, 0, 0, 1'b0, 8'h55};
        vecs[9] = '{8'h01, 1'b1, 1'b0, 0, 0, 1, 1'b0, 8'h55};

        reset = 1'b1;
        Rx = 1'b1;
        tx_active = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data",    int'(rx_data),    0);
        check("reset_rx_valid",   int'(rx_valid),   0);
        check("reset_addr_match", int'(addr_match), 0);
        check("reset_addressed",  int'(addressed),  0);
        check("reset_frame_err",  int'(frame_err),  0);
        check("reset_busy",       int'(busy),       0);
        reset = 1'b0;
        repeat (4) @(posedge clk);

        // ---------------- table-driven frames ----------------
        for (int i = 0; i < 10; i++) begin
            clear_counts();
            send_frame(vecs[i].dat, vecs[i].mode, vecs[i].stop, 11, -1);
            repeat (4) @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_rx_valid_cnt", i),   n_valid, vecs[i].e_valid);
            check($sformatf("v%0d_addr_match_cnt", i), n_match, vecs[i].e_match);
            check($sformatf("v%0d_frame_err_cnt", i),  n_err,   vecs[i].e_err);
            check($sformatf("v%0d_addressed", i), int'(addressed), int'(vecs[i].e_addr));
            check($sformatf("v%0d_rx_data", i),   int'(rx_data),   int'(vecs[i].e_data));
            check($sformatf("v%0d_busy", i),      int'(busy),      0);
            if (vecs[i].e_valid + vecs[i].e_match + vecs[i].e_err > 0)
                check($sformatf("v%0d_latency", i), last_cyc - t_start, LAT);
        end

        // ---------------- 4-clk low glitch on idle line ----------------
        clear_counts();
        @(posedge clk);
        #1 Rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 Rx = 1'b1;
        @(negedge clk);
        check("glitch_busy_during", int'(busy), 1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_after", int'(busy), 0);
        check("glitch_pulses", n_valid + n_match + n_err, 0);
        check("glitch_addressed", int'(addressed), 0);

        // ---------------- tx_active abort while addressed ----------------
        clear_counts();
        send_frame(8'h01, 1'b1, 1'b1, 11, -1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_pre_addressed", int'(addressed), 1);
        clear_counts();
        fork
            send_frame(8'h3F, 1'b0, 1'b1, 11, -1);
            begin
                repeat (40) @(posedge clk);
                @(negedge clk);
                check("abort_busy_before", int'(busy), 1);
                @(posedge clk);
                #1 tx_active = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("abort_busy_next_clk", int'(busy), 0);
                n_busy_tx = 0;
            end
        join
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_busy_while_tx", n_busy_tx, 0);
        check("abort_pulses", n_valid + n_match + n_err, 0);
        check("abort_addressed", int'(addressed), 1);
        #1 tx_active = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_busy_release", int'(busy), 0);

        // ---------------- reset during DATA bit 4 ----------------
        clear_counts();
        send_frame(8'hC3, 1'b0, 1'b1, 5, -1);
        @(negedge clk);
        check("rst_busy_before", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy",      int'(busy),      0);
        check("rst_addressed", int'(addressed), 0);
        check("rst_rx_data",   int'(rx_data),   0);
        check("rst_pulses",    int'(rx_valid) + int'(addr_match) + int'(frame_err), 0);
        repeat (5) @(posedge clk);
        clear_counts();
        send_frame(8'h01, 1'b1, 1'b1, 11, -1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("post_rst_match",     n_match, 1);
        check("post_rst_addressed", int'(addressed), 1);
        clear_counts();
        send_frame(8'hC3, 1'b0, 1'b1, 11, -1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("post_rst_valid",   n_valid, 1);
        check("post_rst_rx_data", int'(rx_data), 8'hC3);
        check("post_rst_latency", last_cyc - t_start, LAT);

        // ---------------- break: line held low ----------------
        clear_counts();
        @(posedge clk);
        #1 Rx = 1'b0;
        repeat (400) @(posedge clk);
        @(negedge clk);
        check("break_err_cnt", n_err, 1);
        check("break_busy",    int'(busy), 0);
        #1 Rx = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("break_err_after",   n_err, 1);
        check("break_other",       n_valid + n_match, 0);
        check("break_addressed",   int'(addressed), 1);
        clear_counts();
        send_frame(8'h5A, 1'b0, 1'b1, 11, -1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rearm_valid",   n_valid, 1);
        check("rearm_rx_data", int'(rx_data), 8'h5A);

`ifdef RX_MAJORITY_EN
        // ---------------- 1-clk spike at mid data bit 2 ----------------
        clear_counts();
        send_frame(8'hA5, 1'b0, 1'b1, 11, 3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("spike_valid",   n_valid, 1);
        check("spike_rx_data", int'(rx_data), 8'hA5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
